// File: rtl/main_mem_responder_pkg.sv
// Shared types and constants for the cache-side main-memory responder.
// Holds the FSM state type, default latencies and the byte-to-word address helper.
package mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 4096;
  localparam int unsigned DEF_ROW_BITS    = 10;
  localparam int unsigned DEF_MISS_LAT    = 10;
  localparam int unsigned DEF_HIT_LAT     = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Word index of a byte address, wrapped modulo the (power-of-two) array depth.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                   input int unsigned       depth);
    return (addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Word interface between the cache (master) and the main-memory responder (slave).
interface main_mem_responder_if;
  import mem_pkg::*;

  logic              mem_ren;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_din;
  logic [WORD_W-1:0] mem_dout;
  logic              mem_rdy;
  logic              mem_busy;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_din,
    input  mem_dout, mem_rdy, mem_busy
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_din,
    output mem_dout, mem_rdy, mem_busy
  );

endinterface

// File: rtl/main_mem_responder_array.sv
// Single-port word array: synchronous write, registered read.
// The storage itself is never reset; only the read register is.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter bit          INIT_PATTERN = 1'b1,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Simulation preload: word i holds i, so reads are predictable without prior writes.
  initial begin
    if (INIT_PATTERN) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[i] = WORD_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts one read/write at a time, models an open-row
// latency (hit vs miss) and completes with a one-cycle mem_rdy pulse.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter int unsigned ROW_BITS     = DEF_ROW_BITS,
  parameter int unsigned MISS_LAT     = DEF_MISS_LAT,
  parameter int unsigned HIT_LAT      = DEF_HIT_LAT,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  main_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(MISS_LAT) + 1;
  localparam int unsigned RW = WORD_W - ROW_BITS;

  mem_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              wr_q, wr_d;
  logic [RW-1:0]     open_row_q, open_row_d;
  logic              open_vld_q, open_vld_d;

  logic [AW-1:0]     idx_in;
  logic [RW-1:0]     row_in;
  logic              req;
  logic              hit;
  logic [CW-1:0]     lat_m1;
  logic [AW-1:0]     arr_addr;
  logic              arr_we;
  logic              arr_re;

  assign idx_in = AW'(word_index(bus.mem_addr, DEPTH_WORDS));
  assign row_in = bus.mem_addr[WORD_W-1:ROW_BITS];
  assign req    = bus.mem_ren | bus.mem_wen;
  assign hit    = open_vld_q && (row_in == open_row_q);
  assign lat_m1 = hit ? CW'(HIT_LAT - 1) : CW'(MISS_LAT - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    wr_d       = wr_q;
    open_row_d = open_row_q;
    open_vld_d = open_vld_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = idx_in;
          din_d      = bus.mem_din;
          wr_d       = bus.mem_wen;  // write wins when both are raised
          open_row_d = row_in;
          open_vld_d = 1'b1;
          cnt_d      = lat_m1;
          state_d    = (lat_m1 == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      open_row_q <= '0;
      open_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      open_row_q <= open_row_d;
      open_vld_q <= open_vld_d;
    end
  end

  // Read data is fetched on the edge entering RESP so it is valid alongside mem_rdy;
  // a write commits on the edge leaving RESP, so a reset in WAIT drops it.
  assign arr_addr = (state_q == IDLE) ? idx_in : addr_q;
  assign arr_re   = (state_d == RESP) && !wr_d;
  assign arr_we   = (state_q == RESP) && wr_q;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_PATTERN(INIT_PATTERN)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(din_q),
    .rdata(bus.mem_dout)
  );

  assign bus.mem_rdy  = (state_q == RESP);
  assign bus.mem_busy = (state_q != IDLE);

endmodule
